// File: rtl/costas_nco_pkg.sv
// Shared widths, quadrant encoding and sample type for the Costas-loop NCO.
// Also holds the elaboration-time generator for the quarter-wave sine table.
package costas_nco_pkg;

  localparam int unsigned PHASE_W   = 24;
  localparam int unsigned LUT_AW    = 8;
  localparam int unsigned AMP_W     = 12;
  localparam int unsigned ROM_W     = AMP_W - 1;
  localparam int unsigned ROM_DEPTH = 1 << LUT_AW;

  typedef logic signed [AMP_W-1:0] iq_sample_t;

  typedef enum logic [1:0] {Quad0, Quad1, Quad2, Quad3} quad_e;

  // Fixed-point (Q30) constants for the integer-only Taylor evaluation
  localparam int     FIX_F  = 30;
  localparam longint PI_FIX = 64'sd3373259426;

  // rom[k] = round(2047 * sin(pi * (2k+1) / 1024)), evaluated with a 10-term series
  function automatic logic [ROM_DEPTH*ROM_W-1:0] gen_sine_rom();
    logic [ROM_DEPTH*ROM_W-1:0] bits;
    longint x, x2, term, sum;
    bits = '0;
    for (int k = 0; k < int'(ROM_DEPTH); k++) begin
      x    = (PI_FIX * longint'(2 * k + 1)) >>> (LUT_AW + 2);
      x2   = (x * x) >>> FIX_F;
      term = x;
      sum  = x;
      for (int n = 1; n <= 10; n++) begin
        term = -(((term * x2) >>> FIX_F) / longint'((2 * n) * (2 * n + 1)));
        sum  = sum + term;
      end
      bits[k*ROM_W +: ROM_W] = ROM_W'((sum * 64'sd2047 + (64'sd1 <<< (FIX_F - 1))) >>> FIX_F);
    end
    return bits;
  endfunction

endpackage

// File: rtl/costas_nco_if.sv
// Control-word inputs and I/Q sample outputs of the NCO, grouped as one bus.
interface costas_nco_if;
  import costas_nco_pkg::*;

  logic                 en;
  logic                 phase_clr;
  logic [PHASE_W-1:0]   freq_word;
  logic [PHASE_W-1:0]   pd;
  iq_sample_t           cos_out;
  iq_sample_t           sin_out;
  logic                 out_valid;

  modport master (
    output en, phase_clr, freq_word, pd,
    input  cos_out, sin_out, out_valid
  );

  modport slave (
    input  en, phase_clr, freq_word, pd,
    output cos_out, sin_out, out_valid
  );

endinterface

// File: rtl/costas_sine_rom.sv
// Quarter-wave sine ROM with two registered read ports (pipeline stage 2).
module costas_sine_rom
  import costas_nco_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LUT_AW-1:0] addr_a,
  input  logic [LUT_AW-1:0] addr_b,
  output logic [ROM_W-1:0]  data_a,
  output logic [ROM_W-1:0]  data_b
);

  localparam logic [ROM_DEPTH*ROM_W-1:0] RomBits = gen_sine_rom();

  logic [ROM_W-1:0] data_a_q, data_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      data_a_q <= RomBits[int'(addr_a)*ROM_W +: ROM_W];
      data_b_q <= RomBits[int'(addr_b)*ROM_W +: ROM_W];
    end
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;

endmodule

// File: rtl/costas_nco.sv
// Costas-loop NCO: phase accumulator feeding a 3-stage quarter-wave cos/sin pipeline.
module costas_nco
  import costas_nco_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  costas_nco_if.slave  bus
);

  logic [PHASE_W-1:0] phase_acc_q, phase_acc_d;
  quad_e              q1_q, q2_q;
  logic [LUT_AW-1:0]  a1_q;
  logic               v1_q, v2_q, valid_q;
  logic [ROM_W-1:0]   rom_r, rom_rm;
  iq_sample_t         sin_q, cos_q, sin_d, cos_d;
  iq_sample_t         pos_r, pos_rm;

  // Clear wins over advance; signed pd wraps correctly with plain modular addition
  always_comb begin
    phase_acc_d = phase_acc_q;
    if (bus.phase_clr) begin
      phase_acc_d = '0;
    end else if (bus.en) begin
      phase_acc_d = phase_acc_q + bus.freq_word + bus.pd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_acc_q <= '0;
      q1_q        <= Quad0;
      a1_q        <= '0;
      v1_q        <= 1'b0;
      q2_q        <= Quad0;
      v2_q        <= 1'b0;
      valid_q     <= 1'b0;
      sin_q       <= '0;
      cos_q       <= '0;
    end else begin
      phase_acc_q <= phase_acc_d;
      q1_q        <= quad_e'(phase_acc_q[PHASE_W-1 -: 2]);
      a1_q        <= phase_acc_q[PHASE_W-3 -: LUT_AW];
      v1_q        <= bus.en;
      q2_q        <= q1_q;
      v2_q        <= v1_q;
      valid_q     <= v2_q;
      if (v2_q) begin
        sin_q <= sin_d;
        cos_q <= cos_d;
      end
    end
  end

  costas_sine_rom u_rom (
    .clk    (clk),
    .rst    (rst),
    .addr_a (a1_q),
    .addr_b (~a1_q),
    .data_a (rom_r),
    .data_b (rom_rm)
  );

  // ROM entries are never zero and below 2^11, so negation cannot overflow
  always_comb begin
    pos_r  = iq_sample_t'({1'b0, rom_r});
    pos_rm = iq_sample_t'({1'b0, rom_rm});
    sin_d  = pos_r;
    cos_d  = pos_rm;
    unique case (q2_q)
      Quad0: begin sin_d = pos_r;   cos_d = pos_rm;  end
      Quad1: begin sin_d = pos_rm;  cos_d = -pos_r;  end
      Quad2: begin sin_d = -pos_r;  cos_d = -pos_rm; end
      Quad3: begin sin_d = -pos_rm; cos_d = pos_r;   end
    endcase
  end

  assign bus.sin_out   = sin_q;
  assign bus.cos_out   = cos_q;
  assign bus.out_valid = valid_q;

endmodule

// File: doc/costas_nco.md
Name: costas_nco

Overview:
Numerically controlled oscillator that closes the Costas loop on the receive side. It consumes the 24-bit phase control word produced by the loop filter and adds it to a fixed centre-frequency word in a phase accumulator. It emits signed cos/sin local-carrier samples to the I/Q mixers. The sine table is quarter-wave, and the datapath is a 3-stage pipeline.

Parameters:
PHASE_W, 24, phase accumulator / control word width (must equal loop-filter output width)
LUT_AW, 8, quarter-wave ROM address width (256 entries)
AMP_W, 12, signed output amplitude width; ROM peak = 2^(AMP_W-1)-1 = 2047

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
en  in  1  sample strobe; advance the accumulator and launch one output sample
phase_clr  in  1  synchronous accumulator clear
freq_word  in  PHASE_W  unsigned centre-frequency increment
pd  in  PHASE_W  two's-complement loop-filter correction
cos_out  out  AMP_W  signed cosine sample
sin_out  out  AMP_W  signed sine sample
out_valid  out  1  cos_out/sin_out hold a new sample this cycle

Behaviour:
- Reset (rst=1 at a clk edge): phase_acc=0, all pipeline registers=0, cos_out=0, sin_out=0, out_valid=0. Reset mid-operation flushes in-flight samples, and no out_valid is produced for them.
- Accumulator update:
  - If en=1, phase_acc <= phase_acc + freq_word + pd, modulo 2^PHASE_W.
  - pd is signed, but plain PHASE_W-bit addition gives the correct wrap. There is no saturation.
- phase_clr=1: phase_acc <= 0, with priority over en.
  - If en=1 in the same cycle, a sample is still launched using the pre-clear phase.
  - The next sample starts at phase 0.
- Stage 1 (edge after en):
  - Latch q = phase_acc[23:22] (pre-update value) and a = phase_acc[21:14].
  - Latch valid bit v1 = en.
  - Lower bits are truncated, with no dither.
- Stage 2:
  - Issue two ROM reads: r = rom[a] and rm = rom[~a].
  - Register the results with q and v2.
- Stage 3: apply quadrant sign and register the outputs, with out_valid = v2.

  q   sin   cos
  0   r     rm
  1   rm    -r
  2   -r    -rm
  3   -rm   r

- ROM contents: rom[k] = round(2047 * sin(pi/2 * (k+0.5)/256)), unsigned and never zero. Negation cannot overflow.
- Latency: exactly 3 clk cycles from en high to out_valid high. Throughput is one sample per clock; en may be high continuously.
- en=0: the accumulator holds. The pipeline still shifts, so out_valid drops 3 cycles later and cos_out/sin_out hold their last values.
- freq_word and pd are sampled only on cycles with en=1. The loop filter's combinational-to-register output is taken as-is, with no extra input register.

Decomposition:
- Shared package:
  - PHASE_W=24, LUT_AW=8, AMP_W=12
  - quadrant encoding constants
  - a typedef for the signed IQ sample
- Sub-module: costas_sine_rom. Dual-read-port, registered-output, 256x11 unsigned ROM, generated from the formula above (synthesisable initial block or $readmemh file). It contains both reads of stage 2.

Test Plan:
- Reset with freq_word=0, pd=0, en=1 → after 3 cycles out_valid=1 and (sin,cos)=(6,2047) on every cycle; during and 3 cycles after rst, outputs are 0 and out_valid=0.
- freq_word=0x400000, pd=0, en=1 continuous → (sin,cos) repeats (6,2047), (2047,-6), (-6,-2047), (-2047,6).
- freq_word=0x400000, pd=0xC00000 (−0x400000) → phase frozen; output constant (6,2047).
- freq_word=0xFFFFFF, pd=0x000002 → accumulator wraps: sample phases 0x000000, 0x000001, 0x000002 (the increment is 0x000001 after wrap); all give (6,2047); no X/overflow artefacts.
- en toggling 1,0,1,0 with freq_word=0x400000 → out_valid pattern 1,0,1,0 delayed 3 cycles; outputs held during gaps; consecutive valid samples advance one quadrant.
- Simultaneous phase_clr=1 and en=1 at phase 0x800000 → that sample is (-6,-2047); next sample is phase 0, (6,2047). rst asserted with 2 samples in flight → neither appears.
